// File: rtl/fpu_result_stage_pkg.sv
// ============================================================================
// Module      : fpu_result_stage_pkg
// Description : Shared FPU constants: result class encoding, fflags bit
//               positions, and the types used by the result stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_result_stage_pkg;

  localparam int CLASS_W        = 6;
  localparam int CLASS_BIT_ZERO = 0;
  localparam int CLASS_BIT_SUB  = 1;
  localparam int CLASS_BIT_NORM = 2;
  localparam int CLASS_BIT_INF  = 3;
  localparam int CLASS_BIT_QNAN = 4;
  localparam int CLASS_BIT_SNAN = 5;

  localparam logic [CLASS_W-1:0] CLASS_ZERO = 6'b000001;
  localparam logic [CLASS_W-1:0] CLASS_SUB  = 6'b000010;
  localparam logic [CLASS_W-1:0] CLASS_NORM = 6'b000100;
  localparam logic [CLASS_W-1:0] CLASS_INF  = 6'b001000;
  localparam logic [CLASS_W-1:0] CLASS_QNAN = 6'b010000;
  localparam logic [CLASS_W-1:0] CLASS_SNAN = 6'b100000;

  localparam int FFLAG_NV = 4;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_NX = 0;

  typedef logic [4:0] fflags_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    fflags_t     flags;
  } rs_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } rs_state_e;

endpackage

`default_nettype wire

// File: rtl/fpu_result_stage_flag_gen.sv
// ============================================================================
// Module      : fpu_flag_gen
// Description : Combinational IEEE exception flag derivation for a
//               multiply result, from its class and the operand summary.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_flag_gen
  import fpu_result_stage_pkg::*;
(
  input  logic [CLASS_W-1:0] class_i,
  input  logic [23:0]        sig_lo_i,
  input  logic               opNaN_i,
  input  logic               opSNaN_i,
  input  logic               opInf_i,
  input  logic               opZero_i,
  output fflags_t            flags_o
);

  logic nv, of, nx, uf, zero_from_nonzero;
  logic unused_snan_class;

  // A zero result without a zero operand can only come from underflow.
  assign zero_from_nonzero = class_i[CLASS_BIT_ZERO] & ~opZero_i;

  assign nv = opSNaN_i | (class_i[CLASS_BIT_QNAN] & ~opNaN_i);
  assign of = class_i[CLASS_BIT_INF] & ~opInf_i;
  assign nx = of
            | ((class_i[CLASS_BIT_NORM] | class_i[CLASS_BIT_SUB]) & (|sig_lo_i))
            | zero_from_nonzero;
  assign uf = nx & (class_i[CLASS_BIT_SUB] | zero_from_nonzero);

  assign unused_snan_class = class_i[CLASS_BIT_SNAN];

  always_comb begin
    flags_o           = '0;
    flags_o[FFLAG_NV] = nv;
    flags_o[FFLAG_DZ] = 1'b0;
    flags_o[FFLAG_OF] = of;
    flags_o[FFLAG_UF] = uf;
    flags_o[FFLAG_NX] = nx;
  end

endmodule

`default_nettype wire

// File: rtl/fpu_result_stage.sv
// ============================================================================
// Module      : fpu_result_stage
// Description : FPU multiply result stage: flag generation, 2-entry elastic
//               buffer (main + skid) and sticky fflags register.
//               FPU_FFLAGS_ACCUM_EN enables the sticky fflags / CSR path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_result_stage
  import fpu_result_stage_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [31:0]        result_i,
  input  logic [CLASS_W-1:0] class_i,
  input  logic [47:0]        sig_i,
  input  logic               opNaN_i,
  input  logic               opSNaN_i,
  input  logic               opInf_i,
  input  logic               opZero_i,
  input  logic [4:0]         rd_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [31:0]        result_o,
  output logic [4:0]         rd_o,
  output fflags_t            flags_o,
  input  logic               fflagsWe_i,
  input  fflags_t            fflagsWdata_i,
  output fflags_t            fflags_o
);

  rs_state_e state_q, state_d;
  rs_entry_t main_q, main_d, skid_q, skid_d, in_entry;
  logic      valid_q, valid_d, ready_q, ready_d;
  logic      accept, handshake;
  fflags_t   in_flags;
  logic      unused_sig_hi;

  assign unused_sig_hi = ^sig_i[47:24];

  fpu_flag_gen u_flag_gen (
    .class_i  (class_i),
    .sig_lo_i (sig_i[23:0]),
    .opNaN_i  (opNaN_i),
    .opSNaN_i (opSNaN_i),
    .opInf_i  (opInf_i),
    .opZero_i (opZero_i),
    .flags_o  (in_flags)
  );

  assign in_entry  = '{result: result_i, rd: rd_i, flags: in_flags};
  assign accept    = valid_i & ready_q;
  assign handshake = valid_q & ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = in_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        case ({accept, handshake})
          2'b11: main_d = in_entry;
          2'b10: begin
            skid_d  = in_entry;
            state_d = ST_FULL;
          end
          2'b01: state_d = ST_EMPTY;
          default: ;
        endcase
      end
      ST_FULL: begin
        // ready_o is low here, so only a drain can happen.
        if (handshake) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    valid_d = (state_d != ST_EMPTY);
    ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign valid_o  = valid_q;
  assign ready_o  = ready_q;
  assign result_o = main_q.result;
  assign rd_o     = main_q.rd;
  assign flags_o  = main_q.flags;

`ifdef FPU_FFLAGS_ACCUM_EN
  fflags_t fflags_q, fflags_d;

  // The retiring op's flags are OR-ed on top of any same-cycle CSR write.
  always_comb begin
    fflags_d = fflags_q;
    if (fflagsWe_i) fflags_d = fflagsWdata_i;
    if (handshake)  fflags_d = fflags_d | main_q.flags;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) fflags_q <= '0;
    else       fflags_q <= fflags_d;
  end

  assign fflags_o = fflags_q;
`else
  logic unused_fflags_csr;
  assign unused_fflags_csr = fflagsWe_i ^ (^fflagsWdata_i);
  assign fflags_o          = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fpu_result_stage.sv
// ============================================================================
// Module      : tb_fpu_result_stage
// Description : Self-checking bench for fpu_result_stage against a queue
//               reference model. Honours FPU_FFLAGS_ACCUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_result_stage;
  import fpu_result_stage_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, ready_i, opNaN_i, opSNaN_i, opInf_i, opZero_i, fflagsWe_i;
  logic [31:0] result_i;
  logic [5:0]  class_i;
  logic [47:0] sig_i;
  logic [4:0]  rd_i, fflagsWdata_i;
  logic        ready_o, valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o, flags_o, fflags_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic [4:0]  fl;
  } ment_t;

  ment_t      mq[$];
  logic [4:0] mf = 5'b0;

  fpu_result_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .result_i(result_i), .class_i(class_i), .sig_i(sig_i),
    .opNaN_i(opNaN_i), .opSNaN_i(opSNaN_i), .opInf_i(opInf_i), .opZero_i(opZero_i),
    .rd_i(rd_i), .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .rd_o(rd_o), .flags_o(flags_o), .fflagsWe_i(fflagsWe_i),
    .fflagsWdata_i(fflagsWdata_i), .fflags_o(fflags_o)
  );

  always #5 clk_i = ~clk_i;

  // IEEE flag rules for a multiply result, {NV,DZ,OF,UF,NX}.
  function automatic logic [4:0] ref_flags();
    bit is_zero, is_sub, is_norm, is_inf, is_qnan, nv, of, nx, uf, tiny_zero;
    is_zero = (class_i == CLASS_ZERO);
    is_sub  = (class_i == CLASS_SUB);
    is_norm = (class_i == CLASS_NORM);
    is_inf  = (class_i == CLASS_INF);
    is_qnan = (class_i == CLASS_QNAN);
    tiny_zero = is_zero && !opZero_i;
    nv = opSNaN_i || (is_qnan && !opNaN_i);
    of = is_inf && !opInf_i;
    nx = of || ((is_norm || is_sub) && (sig_i[23:0] != 24'd0)) || tiny_zero;
    uf = nx && (is_sub || tiny_zero);
    return {nv, 1'b0, of, uf, nx};
  endfunction

  task automatic model_edge();
    bit hs, acc;
    if (rst_i) begin
      mq.delete();
      mf = 5'b0;
    end else begin
      hs  = (mq.size() > 0) && ready_i;
      acc = valid_i && (mq.size() < 2);
`ifdef FPU_FFLAGS_ACCUM_EN
      if (fflagsWe_i) mf = fflagsWdata_i;
      if (hs) mf = mf | mq[0].fl;
`endif
      if (acc) mq.push_back('{res: result_i, rd: rd_i, fl: ref_flags()});
      if (hs) void'(mq.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rst_i = 0; valid_i = 0; ready_i = 1; result_i = '0; class_i = CLASS_NORM;
    sig_i = '0; opNaN_i = 0; opSNaN_i = 0; opInf_i = 0; opZero_i = 0; rd_i = '0;
    fflagsWe_i = 0; fflagsWdata_i = '0;
  endtask

  task automatic set_op(input logic [5:0] c, input logic [31:0] r, input logic [47:0] s,
                        input logic nan, input logic snan, input logic inf,
                        input logic zero, input logic [4:0] d);
    valid_i = 1; class_i = c; result_i = r; sig_i = s;
    opNaN_i = nan; opSNaN_i = snan; opInf_i = inf; opZero_i = zero; rd_i = d;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1; fflagsWe_i = 1; fflagsWdata_i = 5'b11111;
    tick(); tick();
    idle_inputs();
    total++; if (valid_o !== 1'b0)   begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    total++; if (ready_o !== 1'b1)   begin bad++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    total++; if (result_o !== 32'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", result_o); end
    total++; if (rd_o !== 5'd0)      begin bad++; $display("FAIL reset_rd got=%h exp=0", rd_o); end
    total++; if (flags_o !== 5'd0)   begin bad++; $display("FAIL reset_flags got=%b exp=0", flags_o); end
    total++; if (fflags_o !== 5'd0)  begin bad++; $display("FAIL reset_fflags got=%b exp=0", fflags_o); end
  endtask

  task automatic test_inf_times_zero();
    idle_inputs();
    set_op(CLASS_QNAN, 32'h7FC00000, 48'h0, 0, 0, 1, 1, 5'd7);
    tick();
    valid_i = 0;
    total++; if (valid_o !== 1'b1)     begin bad++; $display("FAIL infzero_valid got=%b exp=1", valid_o); end
    total++; if (flags_o !== 5'b10000) begin bad++; $display("FAIL infzero_flags got=%b exp=10000", flags_o); end
    total++; if (rd_o !== 5'd7)        begin bad++; $display("FAIL infzero_rd got=%0d exp=7", rd_o); end
    tick();
    total++; if (fflags_o !== mf)      begin bad++; $display("FAIL infzero_fflags got=%b exp=%b", fflags_o, mf); end
    total++; if (valid_o !== 1'b0)     begin bad++; $display("FAIL infzero_drain got=%b exp=0", valid_o); end
  endtask

  task automatic test_overflow_underflow();
    idle_inputs();
    set_op(CLASS_INF, 32'h7F800000, 48'h123456789ABC, 0, 0, 0, 0, 5'd1);
    tick();
    set_op(CLASS_ZERO, 32'h0, 48'h0, 0, 0, 0, 0, 5'd2);
    total++; if (flags_o !== 5'b00101)       begin bad++; $display("FAIL overflow_flags got=%b exp=00101", flags_o); end
    total++; if (result_o !== 32'h7F800000)  begin bad++; $display("FAIL overflow_result got=%h exp=7f800000", result_o); end
    tick();
    set_op(CLASS_NORM, 32'h3F800000, 48'hABCDEF000000, 0, 0, 0, 0, 5'd3);
    total++; if (flags_o !== 5'b00011)       begin bad++; $display("FAIL underflow_flags got=%b exp=00011", flags_o); end
    tick();
    valid_i = 0;
    total++; if (flags_o !== 5'b00000)       begin bad++; $display("FAIL exact_norm_flags got=%b exp=00000", flags_o); end
    tick();
    total++; if (fflags_o !== mf)            begin bad++; $display("FAIL ovf_unf_fflags got=%b exp=%b", fflags_o, mf); end
  endtask

  task automatic test_backpressure();
    idle_inputs();
    ready_i = 0;
    set_op(CLASS_NORM, 32'hAAAA0001, 48'h0, 0, 0, 0, 0, 5'd10); tick();
    set_op(CLASS_NORM, 32'hBBBB0002, 48'h0, 0, 0, 0, 0, 5'd11); tick();
    set_op(CLASS_NORM, 32'hCCCC0003, 48'h0, 0, 0, 0, 0, 5'd12);
    total++; if (ready_o !== 1'b0)          begin bad++; $display("FAIL bp_full_ready got=%b exp=0", ready_o); end
    tick();
    total++; if (result_o !== 32'hAAAA0001) begin bad++; $display("FAIL bp_hold_A got=%h exp=aaaa0001", result_o); end
    ready_i = 1;
    tick();
    total++; if (result_o !== 32'hBBBB0002 || rd_o !== 5'd11) begin bad++; $display("FAIL bp_B got=%h/%0d exp=bbbb0002/11", result_o, rd_o); end
    total++; if (ready_o !== 1'b1)          begin bad++; $display("FAIL bp_ready_again got=%b exp=1", ready_o); end
    tick();
    valid_i = 0;
    total++; if (result_o !== 32'hCCCC0003 || valid_o !== 1'b1) begin bad++; $display("FAIL bp_C got=%h v=%b exp=cccc0003 v=1", result_o, valid_o); end
    tick();
    total++; if (valid_o !== 1'b0)          begin bad++; $display("FAIL bp_no_dup got=%b exp=0", valid_o); end
  endtask

  task automatic test_csr_same_cycle();
    idle_inputs();
    ready_i = 0;
    set_op(CLASS_NORM, 32'h40000000, 48'h000000000001, 0, 0, 0, 0, 5'd4);
    tick();
    valid_i = 0;
    total++; if (flags_o !== 5'b00001) begin bad++; $display("FAIL csr_op_flags got=%b exp=00001", flags_o); end
    ready_i = 1; fflagsWe_i = 1; fflagsWdata_i = 5'b00000;
    tick();
    fflagsWe_i = 0;
    total++; if (fflags_o !== mf)      begin bad++; $display("FAIL csr_same_cycle got=%b exp=%b", fflags_o, mf); end
  endtask

  task automatic test_mid_reset();
    idle_inputs();
    ready_i = 0;
    set_op(CLASS_SUB, 32'h00000011, 48'hFFFFFF, 0, 0, 0, 0, 5'd5); tick();
    set_op(CLASS_INF, 32'h7F800000, 48'h0, 0, 0, 0, 0, 5'd6);      tick();
    valid_i = 0;
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL midrst_full got=%b exp=0", ready_o); end
    rst_i = 1; ready_i = 1; fflagsWe_i = 1; fflagsWdata_i = 5'b11111;
    tick();
    idle_inputs();
    total++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || fflags_o !== 5'd0)
      begin bad++; $display("FAIL midrst_state got v=%b r=%b ff=%b exp v=0 r=1 ff=00000", valid_o, ready_o, fflags_o); end
  endtask

  task automatic test_random();
    int errs = 0;
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      logic [47:0] s;
      total++;
      if (valid_o !== (mq.size() > 0) || ready_o !== (mq.size() < 2) || fflags_o !== mf ||
          (mq.size() > 0 && (result_o !== mq[0].res || rd_o !== mq[0].rd || flags_o !== mq[0].fl))) begin
        bad++;
        if (errs < 10)
          $display("FAIL random_cycle%0d got v=%b r=%b res=%h rd=%0d fl=%b ff=%b exp v=%0d r=%0d ff=%b",
                   i, valid_o, ready_o, result_o, rd_o, flags_o, fflags_o, mq.size() > 0, mq.size() < 2, mf);
        errs++;
      end
      s = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) s[23:0] = 24'd0;
      valid_i  = ($urandom_range(0, 3) != 0);
      ready_i  = ($urandom_range(0, 2) != 0);
      class_i  = 6'b1 << $urandom_range(0, 5);
      result_i = $urandom;
      sig_i    = s;
      rd_i     = 5'($urandom);
      opNaN_i  = 1'($urandom); opSNaN_i = 1'($urandom);
      opInf_i  = 1'($urandom); opZero_i = 1'($urandom);
      fflagsWe_i    = ($urandom_range(0, 9) == 0);
      fflagsWdata_i = 5'($urandom);
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_inf_times_zero();
    test_overflow_underflow();
    test_backpressure();
    test_csr_same_cycle();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fpu_result_stage.md
FPU_RESULT_STAGE -- requirements
Module: fpu_result_stage

Interface
- REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk_i input 1 (rising-edge clock), then rst_i input 1 (synchronous active-high reset).
- REQ-002 valid_i, input, 1: the upstream multiply result is valid this cycle.
- REQ-003 ready_o, output, 1: the block can accept an input this cycle.
- REQ-004 result_i, input, 32: packed single-precision result.
- REQ-005 class_i, input, 6: one-hot result class (CLASS_* encoding).
- REQ-006 sig_i, input, 48: normalized significand product, before rounding.
- REQ-007 opNaN_i, opSNaN_i, opInf_i, opZero_i, inputs, 1 each: any operand is NaN, any operand is sNaN, any operand is infinite, any operand is zero.
- REQ-008 rd_i, input, 5: destination register tag.
- REQ-009 valid_o, output, 1: a retired result is presented downstream.
- REQ-010 ready_i, input, 1: downstream accepts the result.
- REQ-011 result_o (32), rd_o (5), flags_o (5), outputs: the registered result, its tag, and the per-operation exception flags {NV,DZ,OF,UF,NX}.
- REQ-012 fflagsWe_i (1) and fflagsWdata_i (5), inputs: CSR write to the sticky flags.
- REQ-013 fflags_o, output, 5: sticky accumulated fflags.

Function
- REQ-014 Flag generation SHALL be combinational on the input side: NV = opSNaN_i | (class_i QNAN & !opNaN_i); DZ = 0; OF = class_i INF & !opInf_i.
- REQ-015 NX SHALL be computed as OF | ((class_i NORM|SUB) & |sig_i[23:0]) | (class_i ZERO & !opZero_i).
- REQ-016 UF SHALL be computed as NX & (class_i SUB | (class_i ZERO & !opZero_i)).
- REQ-017 The block SHALL be a 2-entry elastic buffer (main plus skid) with a latency of 1 cycle from an accepted input (valid_i & ready_o) to valid_o.
- REQ-018 ready_o SHALL be driven directly from a register and equal "skid entry empty"; it has no combinational path from ready_i.
- REQ-019 States: EMPTY (no valid entry), ONE (main entry valid), FULL (main and skid valid).
- REQ-020 EMPTY to ONE on accept.
- REQ-021 ONE stays ONE on accept together with a downstream handshake (valid_o & ready_i).
- REQ-022 ONE goes to FULL on accept without a downstream handshake.
- REQ-023 ONE goes to EMPTY on a downstream handshake without an accept.
- REQ-024 FULL goes to ONE on a downstream handshake, and the skid entry moves to main.
- REQ-025 No accept SHALL occur in FULL.
- REQ-026 Outputs SHALL be held stable while valid_o & !ready_i.
- REQ-027 Ordering SHALL be strictly FIFO.
- REQ-028 fflags_o SHALL be updated on the downstream handshake: fflags <= fflags | flags_o.
- REQ-029 When fflagsWe_i and a downstream handshake occur in the same cycle, the new value SHALL be fflagsWdata_i | flags_o; the retiring operation's flags are never lost.

Reset
- REQ-030 On rst_i at a clock edge: state is EMPTY; valid_o=0; ready_o=1; result_o=0; rd_o=0; flags_o=0; fflags_o=0.
- REQ-031 Reset SHALL take precedence over any in-flight handshake or CSR write in the same cycle; buffered entries are discarded.

Configuration
- REQ-032 FPU_FFLAGS_ACCUM_EN defined: the sticky fflags register and CSR write path SHALL be present as specified above.
- REQ-033 FPU_FFLAGS_ACCUM_EN undefined: fflags_o SHALL be tied to 0, and fflagsWe_i/fflagsWdata_i are ignored; flags_o and the datapath are unchanged.

Structure
- REQ-034 The shared FPU package/include SHALL hold the CLASS_BIT_* and CLASS_* constants (already shared), plus new FFLAG_NV=4, FFLAG_DZ=3, FFLAG_OF=2, FFLAG_UF=1, FFLAG_NX=0 and a 5-bit fflags typedef.
- REQ-035 The flag derivation (REQ-014 to REQ-016) SHALL be one combinational sub-module, fpu_flag_gen; the buffer and sticky register live in fpu_result_stage.

Verification
- REQ-036 Inf x 0: class_i=QNAN, opInf_i=1, opZero_i=1, opNaN_i=0 -> next cycle valid_o=1, flags_o=10000, fflags_o=10000 after the handshake.
- REQ-037 Overflow: class_i=INF, result_i=0x7F800000, opInf_i=0 -> flags_o=00101 (OF, NX).
- REQ-038 Underflow to zero: class_i=ZERO, opZero_i=0 -> flags_o=00011; a normal result with sig_i[23:0]=0 -> flags_o=00000.
- REQ-039 Backpressure: ready_i=0, issue 3 valid_i back-to-back -> first two accepted, ready_o=0 in FULL; raise ready_i -> results out in order A, B, then C accepted, with no drop or duplicate.
- REQ-040 Same-cycle CSR write: fflagsWe_i=1, fflagsWdata_i=00000, with a retiring op whose flags_o=00001 -> fflags_o=00001.
- REQ-041 Mid-operation reset: assert rst_i in FULL -> next cycle valid_o=0, ready_o=1, fflags_o=0.
